// File: rtl/saturn_tl_port.sv
`default_nettype none
// ============================================================================
//  Module   : saturn_tl_port
//  Purpose  : Single-port emulator of the Saturn TH/TR/TL handshake. Streams
//             an N-nibble report (snapshotted at session start) into the SMPC
//             port input register, with a programmable acknowledge delay.
//  Options  : define SATPAD_TIMEOUT_EN to abort sessions stalled for TIMEOUT
//             CE ticks in ACTIVE/HOLD.
//  Revision : 1.0 - initial release
// ============================================================================
module saturn_tl_port #(
    parameter int         MAX_NIB   = 16,
    parameter int         LEN_W     = 5,
    parameter int         ACK_DELAY = 0,
    parameter int         TIMEOUT   = 255,
    parameter logic [3:0] IDLE_NIB  = 4'h0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE,
    input  logic                 ENABLE,
    input  logic [6:0]           PDR_O,
    input  logic [6:0]           DDR,
    output logic [6:0]           PDR_I,
    input  logic [4*MAX_NIB-1:0] REPORT,
    input  logic [LEN_W-1:0]     REPORT_LEN,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int         STEP_W   = LEN_W + 1;
    localparam logic [3:0] DLY_INIT = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic                 tl, tl_nx;
    logic [3:0]           nib, nib_nx;
    logic [STEP_W-1:0]    step, step_nx;
    logic [STEP_W-1:0]    len, len_nx;
    logic [3:0]           dly, dly_nx;
    logic [4*MAX_NIB-1:0] shadow, shadow_nx;
    logic                 done, done_nx;

    logic                 th, tr;
    logic                 abort, accept, timeout_hit;
    logic [STEP_W-1:0]    len_clamp;
    logic [STEP_W-1:0]    step_inc;
    logic [4*MAX_NIB-1:0] shadow_shift;
    logic [3:0]           shadow_nib;

    // Handshake decode: a step is accepted when TH is low and TR matches the
    // level expected for the current step (even steps high, odd steps low).
    always_comb begin
        th           = PDR_O[6];
        tr           = PDR_O[5];
        abort        = th & tr;
        accept       = ~th & (tr == ~step[0]);
        step_inc     = step + STEP_W'(1);
        shadow_shift = shadow >> {step, 2'b00};
        shadow_nib   = shadow_shift[3:0];
    end

    // Requested length clamped to 1..MAX_NIB.
    always_comb begin
        len_clamp = {1'b0, REPORT_LEN};
        if (REPORT_LEN == '0) begin
            len_clamp = STEP_W'(1);
        end else if ({1'b0, REPORT_LEN} > STEP_W'(MAX_NIB)) begin
            len_clamp = STEP_W'(MAX_NIB);
        end
    end

`ifdef SATPAD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] stall_cnt;
    logic            counting;
    logic            step_taken;

    // Stall detection: only ACTIVE/HOLD ticks without an accepted step count.
    always_comb begin
        counting    = (state == ST_ACTIVE) || (state == ST_HOLD);
        step_taken  = accept && (state == ST_ACTIVE);
        timeout_hit = counting && !step_taken && (stall_cnt == TO_W'(TIMEOUT - 1));
    end

    // Stall counter, cleared by any step, abort, idle or wait phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt <= '0;
        end else if (CE) begin
            if (!ENABLE || abort || timeout_hit || !counting || step_taken) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + TO_W'(1);
            end
        end
    end
`else
    // No stall counter: constant false, TIMEOUT has no effect in this build.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // Next-state and datapath update; everything advances only on CE ticks.
    always_comb begin
        state_nx  = state;
        tl_nx     = tl;
        nib_nx    = nib;
        step_nx   = step;
        len_nx    = len;
        dly_nx    = dly;
        shadow_nx = shadow;
        done_nx   = 1'b0;
        if (CE) begin
            if (!ENABLE || abort || timeout_hit) begin
                state_nx = ST_IDLE;
                tl_nx    = 1'b1;
                nib_nx   = IDLE_NIB;
                step_nx  = '0;
                dly_nx   = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            shadow_nx = REPORT;
                            len_nx    = len_clamp;
                            if (ACK_DELAY == 0) begin
                                tl_nx   = 1'b1;
                                nib_nx  = REPORT[3:0];
                                step_nx = STEP_W'(1);
                                if (len_clamp == STEP_W'(1)) begin
                                    state_nx = ST_HOLD;
                                    done_nx  = 1'b1;
                                end else begin
                                    state_nx = ST_ACTIVE;
                                end
                            end else begin
                                dly_nx   = DLY_INIT;
                                state_nx = ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (dly == 4'd0) begin
                            tl_nx   = ~step[0];
                            nib_nx  = shadow_nib;
                            step_nx = step_inc;
                            if (step_inc == len) begin
                                state_nx = ST_HOLD;
                                done_nx  = 1'b1;
                            end else begin
                                state_nx = ST_ACTIVE;
                            end
                        end else begin
                            dly_nx = dly - 4'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (accept) begin
                            if (ACK_DELAY == 0) begin
                                tl_nx   = ~step[0];
                                nib_nx  = shadow_nib;
                                step_nx = step_inc;
                                if (step_inc == len) begin
                                    state_nx = ST_HOLD;
                                    done_nx  = 1'b1;
                                end
                            end else begin
                                dly_nx   = DLY_INIT;
                                state_nx = ST_WAIT;
                            end
                        end
                    end
                    ST_HOLD: begin
                        state_nx = ST_HOLD;
                    end
                    default: begin
                        state_nx = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            tl     <= 1'b1;
            nib    <= IDLE_NIB;
            step   <= '0;
            len    <= '0;
            dly    <= '0;
            shadow <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            tl     <= tl_nx;
            nib    <= nib_nx;
            step   <= step_nx;
            len    <= len_nx;
            dly    <= dly_nx;
            shadow <= shadow_nx;
            done   <= done_nx;
        end
    end

    // Port readback: undriven pins read high, low five bits carry {TL,data}.
    always_comb begin
        PDR_I = (PDR_O & DDR) | ~DDR;
        if (ENABLE) begin
            PDR_I[4:0] = {tl, nib};
        end
    end

    assign BUSY = (state == ST_ACTIVE) || (state == ST_WAIT);
    assign DONE = done;

endmodule
`default_nettype wire

// File: tb/tb_saturn_tl_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_saturn_tl_port
//  Purpose  : Self-checking bench for saturn_tl_port (ACK_DELAY 0 and 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_saturn_tl_port;

    localparam int MN = 16;
    localparam int LW = 5;
    localparam int TO = 8;
    localparam logic [63:0] MOUSE = 64'h0000_0054_3218_0FFB;

    typedef struct packed {
        logic        tl;
        logic [3:0]  nib;
        logic        started;
        logic        hold;
        logic        done;
        int          nsent;
        int          len;
        int          wait_left;
        int          stall;
        logic [63:0] snap;
    } model_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce0 = 1'b1, en0 = 1'b1, ce3 = 1'b0, en3 = 1'b1;
    logic [6:0] pdr0 = 7'h60, ddr0 = 7'h60, pdr3 = 7'h60, ddr3 = 7'h60;
    logic [63:0] rep0 = MOUSE, rep3 = MOUSE;
    logic [4:0]  len0 = 5'd10, len3 = 5'd4;
    logic [6:0]  pdri0, pdri3;
    logic        busy0, done0, busy3, done3;

    int errors = 0;
    int checks = 0;
    model_t m0, m3;
    logic [4:0] exp_tab [10];

    saturn_tl_port #(.MAX_NIB(MN), .LEN_W(LW), .ACK_DELAY(0), .TIMEOUT(TO), .IDLE_NIB(4'h0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .CE(ce0), .ENABLE(en0), .PDR_O(pdr0), .DDR(ddr0),
        .PDR_I(pdri0), .REPORT(rep0), .REPORT_LEN(len0), .BUSY(busy0), .DONE(done0));

    saturn_tl_port #(.MAX_NIB(MN), .LEN_W(LW), .ACK_DELAY(3), .TIMEOUT(TO), .IDLE_NIB(4'h0)) dut3 (
        .CLK(clk), .RST_N(rst_n), .CE(ce3), .ENABLE(en3), .PDR_O(pdr3), .DDR(ddr3),
        .PDR_I(pdri3), .REPORT(rep3), .REPORT_LEN(len3), .BUSY(busy3), .DONE(done3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void msess_reset(inout model_t m);
        m.tl = 1'b1; m.nib = 4'h0; m.started = 1'b0; m.hold = 1'b0;
        m.nsent = 0; m.wait_left = 0; m.stall = 0;
    endfunction

    function automatic void mreset(inout model_t m);
        msess_reset(m);
        m.done = 1'b0; m.len = 1; m.snap = '0;
    endfunction

    function automatic void mpresent(inout model_t m);
        logic [63:0] s;
        s = m.snap >> (4 * m.nsent);
        m.nib = s[3:0];
        m.tl = (m.nsent % 2 == 0);
        m.nsent = m.nsent + 1;
        if (m.nsent == m.len) begin
            m.hold = 1'b1;
            m.done = 1'b1;
        end
    endfunction

    function automatic void mstep(inout model_t m, input logic ce, input logic en,
                                  input logic [6:0] pdr, input logic [63:0] rep,
                                  input logic [4:0] rlen, input int d);
        logic th, tr, acc;
        int c;
        th = pdr[6];
        tr = pdr[5];
        m.done = 1'b0;
        if (!ce) return;
        if (!en || (th && tr)) begin
            msess_reset(m);
            return;
        end
        if (m.wait_left > 0) begin
            m.wait_left = m.wait_left - 1;
            m.stall = 0;
            if (m.wait_left == 0) mpresent(m);
            return;
        end
        acc = !m.hold && !th && (tr == (m.nsent % 2 == 0));
        if (acc) begin
            if (!m.started) begin
                m.started = 1'b1;
                m.snap = rep;
                c = int'(rlen);
                if (c == 0) c = 1;
                if (c > MN) c = MN;
                m.len = c;
            end
            m.stall = 0;
            if (d == 0) mpresent(m);
            else m.wait_left = d;
        end else if (m.started) begin
`ifdef SATPAD_TIMEOUT_EN
            m.stall = m.stall + 1;
            if (m.stall == TO) msess_reset(m);
`endif
        end
    endfunction

    function automatic logic [6:0] exp_pdr(input model_t m, input logic [6:0] p,
                                           input logic [6:0] d, input logic en);
        logic [6:0] v;
        v = (p & d) | ~d;
        if (en) v[4:0] = {m.tl, m.nib};
        return v;
    endfunction

    // Model advances on the same clock edges the DUT samples.
    initial begin
        mreset(m0);
        mreset(m3);
        forever begin
            @(posedge clk);
            if (rst_n) begin
                mstep(m0, ce0, en0, pdr0, rep0, len0, 0);
                mstep(m3, ce3, en3, pdr3, rep3, len3, 3);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("pdr_i_0", 32'(pdri0), 32'(exp_pdr(m0, pdr0, ddr0, en0)));
                chk("busy_0", 32'(busy0), 32'(m0.started && !m0.hold));
                chk("done_0", 32'(done0), 32'(m0.done));
                chk("pdr_i_3", 32'(pdri3), 32'(exp_pdr(m3, pdr3, ddr3, en3)));
                chk("busy_3", 32'(busy3), 32'(m3.started && !m3.hold));
                chk("done_3", 32'(done3), 32'(m3.done));
            end
        end
    end

    // CE for the delayed instance: one tick in four.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            ce3 = (cyc % 4 == 0);
            cyc++;
        end
    end

    task automatic drv0(input logic [1:0] thtr);
        pdr0 = {thtr, 5'h00};
        @(posedge clk);
        #2;
    endtask

    task automatic wce3(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (ce3) k++;
        end
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0] = 5'h1B; exp_tab[1] = 5'h0F; exp_tab[2] = 5'h1F; exp_tab[3] = 5'h00;
        exp_tab[4] = 5'h18; exp_tab[5] = 5'h01; exp_tab[6] = 5'h12; exp_tab[7] = 5'h03;
        exp_tab[8] = 5'h14; exp_tab[9] = 5'h05;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("reset_tl_out", 32'(pdri0[4:0]), 32'h10);
        chk("reset_busy", 32'(busy0), 32'h0);
        chk("reset_done", 32'(done0), 32'h0);

        // Mouse report with mid-session REPORT change (snapshot coherence).
        for (int i = 0; i < 10; i++) begin
            drv0({1'b0, (i % 2 == 0)});
            chk("mouse_nib", 32'(pdri0[4:0]), 32'(exp_tab[i]));
            if (i == 2) rep0 = '0;
            if (i < 9) chk("mouse_busy", 32'(busy0), 32'h1);
        end
        chk("mouse_done", 32'(done0), 32'h1);
        chk("mouse_busy_end", 32'(busy0), 32'h0);
        drv0(2'b00);
        chk("hold_done_clear", 32'(done0), 32'h0);
        chk("hold_frozen", 32'(pdri0[4:0]), 32'h05);
        drv0(2'b01);
        chk("hold_frozen2", 32'(pdri0[4:0]), 32'h05);
        drv0(2'b11);
        chk("hold_abort", 32'(pdri0[4:0]), 32'h10);

        // Stall in the middle of a session.
        rep0 = MOUSE;
        drv0(2'b01); drv0(2'b00); drv0(2'b01);
        chk("stall_start", 32'(pdri0[4:0]), 32'h1F);
        repeat (7) @(posedge clk);
        #2;
        chk("stall_7", 32'(pdri0[4:0]), 32'h1F);
        @(posedge clk);
        #2;
`ifdef SATPAD_TIMEOUT_EN
        chk("stall_8_timeout", 32'(pdri0[4:0]), 32'h10);
        chk("stall_8_busy", 32'(busy0), 32'h0);
`else
        chk("stall_8_held", 32'(pdri0[4:0]), 32'h1F);
        repeat (12) @(posedge clk);
        #2;
        chk("stall_20_held", 32'(pdri0[4:0]), 32'h1F);
        chk("stall_20_busy", 32'(busy0), 32'h1);
`endif
        drv0(2'b11);

        // Abort after four nibbles, then restart at nibble 0.
        for (int i = 0; i < 4; i++) drv0({1'b0, (i % 2 == 0)});
        chk("pre_abort", 32'(pdri0[4:0]), 32'h00);
        drv0(2'b11);
        chk("abort_out", 32'(pdri0[4:0]), 32'h10);
        chk("abort_done", 32'(done0), 32'h0);
        chk("abort_busy", 32'(busy0), 32'h0);
        drv0(2'b01);
        chk("restart_nib0", 32'(pdri0[4:0]), 32'h1B);
        drv0(2'b11);

        // Length 0 behaves as length 1.
        len0 = 5'd0;
        drv0(2'b01);
        chk("len0_out", 32'(pdri0[4:0]), 32'h1B);
        chk("len0_done", 32'(done0), 32'h1);
        chk("len0_busy", 32'(busy0), 32'h0);
        drv0(2'b11);

        // Length above MAX_NIB clamps to 16.
        rep0 = 64'hFEDC_BA98_7654_3210;
        len0 = 5'd31;
        for (int i = 0; i < 16; i++) begin
            drv0({1'b0, (i % 2 == 0)});
            chk("clamp_nib", 32'(pdri0[4:0]), 32'({(i % 2 == 0) ? 1'b1 : 1'b0, 4'(i)}));
        end
        chk("clamp_done", 32'(done0), 32'h1);
        drv0(2'b11);

        // CE low: a valid step level is ignored.
        ce0 = 1'b0;
        drv0(2'b01);
        chk("ce_low_idle", 32'(pdri0[4:0]), 32'h10);
        ce0 = 1'b1;
        drv0(2'b11);

        // Pass-through only when disabled.
        en0 = 1'b0;
        len0 = 5'd1;
        pdr0 = 7'h40;
        @(posedge clk);
        #2;
        chk("disabled_pdr", 32'(pdri0), 32'h5F);
        drv0(2'b01);
        chk("disabled_pdr2", 32'(pdri0), 32'h3F);
        chk("disabled_done", 32'(done0), 32'h0);
        en0 = 1'b1;
        drv0(2'b11);

        // ACK_DELAY=3 instance, CE one in four.
        pdr3 = 7'h20;
        wce3(3);
        chk("d3_step0_early", 32'(pdri3[4:0]), 32'h10);
        wce3(1);
        chk("d3_step0", 32'(pdri3[4:0]), 32'h1B);
        pdr3 = 7'h00;
        wce3(3);
        chk("d3_step1_early", 32'(pdri3[4:0]), 32'h1B);
        wce3(1);
        chk("d3_step1", 32'(pdri3[4:0]), 32'h0F);
        pdr3 = 7'h20;
        wce3(2);
        pdr3 = 7'h60;
        wce3(1);
        chk("d3_cancel", 32'(pdri3[4:0]), 32'h10);
        wce3(3);
        chk("d3_cancel_late", 32'(pdri3[4:0]), 32'h10);
        chk("d3_cancel_busy", 32'(busy3), 32'h0);
        pdr3 = 7'h20;
        wce3(3);
        pdr3 = 7'h60;
        wce3(1);
        chk("d3_abort_prio", 32'(pdri3[4:0]), 32'h10);
        for (int i = 0; i < 4; i++) begin
            pdr3 = (i % 2 == 0) ? 7'h20 : 7'h00;
            wce3(4);
            chk("d3_nib", 32'(pdri3[4:0]), 32'(exp_tab[i]));
        end
        chk("d3_done", 32'(done3), 32'h1);
        pdr3 = 7'h60;
        wce3(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
